// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alarm_pkg
// Description : Shared state encoding, default timing constants and a width
//               helper for the alarm ring controller.
// Revision    : 1.0 - initial release
// ============================================================================
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } ring_state_t;

    localparam int c_ring_timeout_s_def   = 60;
    localparam int c_snooze_s_def         = 300;
    localparam int c_max_snooze_def       = 3;
    localparam int c_beep_half_cycles_def = 50_000_000;

    // Counter width that never collapses to zero bits for tiny limits.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/beep_gen.sv
`default_nettype none
// ============================================================================
// Module      : beep_gen
// Description : Square-wave buzzer drive; starts high on the enable rise and
//               toggles every BEEP_HALF_CYCLES clocks while enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module beep_gen
    import alarm_pkg::*;
#(
    parameter int BEEP_HALF_CYCLES = c_beep_half_cycles_def
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic buzzer
);

    localparam int              c_cw   = cnt_width(BEEP_HALF_CYCLES);
    localparam logic [c_cw-1:0] c_last = c_cw'(BEEP_HALF_CYCLES - 1);

    logic [c_cw-1:0] r_cnt;
    logic            r_en_q;
    logic            r_buzzer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_en_q   <= 1'b0;
            r_buzzer <= 1'b0;
        end else begin
            r_en_q <= en;
            if (!en) begin
                r_cnt    <= '0;
                r_buzzer <= 1'b0;
            end else if (!r_en_q) begin
                r_cnt    <= '0;
                r_buzzer <= 1'b1;
            end else if (r_cnt == c_last) begin
                r_cnt    <= '0;
                r_buzzer <= ~r_buzzer;
            end else begin
                r_cnt <= r_cnt + c_cw'(1);
            end
        end
    end

    assign buzzer = r_buzzer;

endmodule
`default_nettype wire

// File: rtl/alarm_ring_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alarm_ring_ctrl
// Description : Ring/snooze/stop session sequencer between the alarm-time
//               match and the buzzer pin.
// Config      : ALARM_AUTO_SNOOZE_EN - ring timeout snoozes while budget lasts
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_ring_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_TIMEOUT_S   = c_ring_timeout_s_def,
    parameter int SNOOZE_S         = c_snooze_s_def,
    parameter int MAX_SNOOZE       = c_max_snooze_def,
    parameter int BEEP_HALF_CYCLES = c_beep_half_cycles_def
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            sec_tick,
    input  logic                            alarm_en,
    input  logic                            alarm_match,
    input  logic                            snooze_btn,
    input  logic                            stop_btn,
    output logic                            buzzer,
    output logic                            ringing,
    output logic                            snoozing,
    output logic [$clog2(MAX_SNOOZE+1)-1:0] snooze_cnt
);

    localparam int              c_rw          = cnt_width(RING_TIMEOUT_S);
    localparam int              c_ww          = cnt_width(SNOOZE_S);
    localparam int              c_sw          = $clog2(MAX_SNOOZE + 1);
    localparam logic [c_rw-1:0] c_ring_last   = c_rw'(RING_TIMEOUT_S - 1);
    localparam logic [c_ww-1:0] c_wait_last   = c_ww'(SNOOZE_S - 1);
    localparam logic [c_sw-1:0] c_max_snooze  = c_sw'(MAX_SNOOZE);

    ring_state_t     r_state, w_state_nxt;
    logic [c_rw-1:0] r_ring_cnt, w_ring_cnt_nxt;
    logic [c_ww-1:0] r_wait_cnt, w_wait_cnt_nxt;
    logic [c_sw-1:0] r_snooze_cnt, w_snooze_cnt_nxt;
    logic            r_match_q;
    logic            r_ringing;
    logic            r_snoozing;
    logic            w_trigger;
    logic            w_can_snooze;
    logic            w_beep_en;

    // match_q powers up high so a match already present at reset release never rings.
    assign w_trigger    = alarm_match & ~r_match_q & alarm_en;
    assign w_can_snooze = (r_snooze_cnt < c_max_snooze);
    assign w_beep_en    = (w_state_nxt == RINGING);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_ring_cnt   <= '0;
            r_wait_cnt   <= '0;
            r_snooze_cnt <= '0;
            r_match_q    <= 1'b1;
            r_ringing    <= 1'b0;
            r_snoozing   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ring_cnt   <= w_ring_cnt_nxt;
            r_wait_cnt   <= w_wait_cnt_nxt;
            r_snooze_cnt <= w_snooze_cnt_nxt;
            r_match_q    <= alarm_match;
            r_ringing    <= (w_state_nxt == RINGING);
            r_snoozing   <= (w_state_nxt == SNOOZE);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_ring_cnt_nxt   = r_ring_cnt;
        w_wait_cnt_nxt   = r_wait_cnt;
        w_snooze_cnt_nxt = r_snooze_cnt;
        if (!alarm_en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        w_state_nxt      = RINGING;
                        w_ring_cnt_nxt   = '0;
                        w_snooze_cnt_nxt = '0;
                    end
                end
                RINGING: begin
                    // A snooze press at budget falls through so the tick still counts.
                    if (stop_btn) begin
                        w_state_nxt = IDLE;
                    end else if (snooze_btn && w_can_snooze) begin
                        w_state_nxt      = SNOOZE;
                        w_snooze_cnt_nxt = r_snooze_cnt + c_sw'(1);
                        w_wait_cnt_nxt   = '0;
                    end else if (sec_tick) begin
                        if (r_ring_cnt == c_ring_last) begin
`ifdef ALARM_AUTO_SNOOZE_EN
                            if (w_can_snooze) begin
                                w_state_nxt      = SNOOZE;
                                w_snooze_cnt_nxt = r_snooze_cnt + c_sw'(1);
                                w_wait_cnt_nxt   = '0;
                            end else begin
                                w_state_nxt = IDLE;
                            end
`else
                            w_state_nxt = IDLE;
`endif
                        end else begin
                            w_ring_cnt_nxt = r_ring_cnt + c_rw'(1);
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_btn) begin
                        w_state_nxt = IDLE;
                    end else if (sec_tick) begin
                        if (r_wait_cnt == c_wait_last) begin
                            w_state_nxt    = RINGING;
                            w_ring_cnt_nxt = '0;
                        end else begin
                            w_wait_cnt_nxt = r_wait_cnt + c_ww'(1);
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    beep_gen #(
        .BEEP_HALF_CYCLES (BEEP_HALF_CYCLES)
    ) u_beep_gen (
        .clk    (clk),
        .rst_n  (reset),
        .en     (w_beep_en),
        .buzzer (buzzer)
    );

    assign ringing    = r_ringing;
    assign snoozing   = r_snoozing;
    assign snooze_cnt = r_snooze_cnt;

endmodule
`default_nettype wire
